gen1_descramble: RTL
====================

Name: gen1_descramble

Overview:
- Receive-side Gen1/Gen2 (8b/10b) per-lane descrambler; the inverse of the lane's transmit scrambler.
- Sits between the 8b/10b decoder/elastic buffer and the RX ordered-set/packet parser.
- Accepts 1, 2 or 4 decoded symbols per clock (PIPE width 8/16/32), removes LFSR scrambling from D symbols, and passes K symbols unchanged.
- Tracks COM/SKP and training-set boundaries so the LFSR stays in lock-step with the transmitter.

Parameters:
- LFSR_SEED, 16'hFFFF, LFSR value loaded on COM and at reset.
- TS_BODY_LEN, 15, number of symbols after a COM that are passed unscrambled (TS1/TS2 body).

Ports:
- clk_i  input  1  lane clock
- rst_i  input  1  reset; one clock; reset is synchronous and active-high
- data_in_i  input  32  decoded symbols; byte 0 (bits 7:0) is earliest in time
- data_k_in_i  input  4  K flag per byte
- data_valid_i  input  1  beat qualifier
- pipe_width_i  input  6  8/16/32; active bytes N = pipe_width_i>>3
- disable_scrambling_i  input  1  link-level scrambling disable (from training)
- data_out_o  output  32  descrambled symbols
- data_k_out_o  output  4  K flags, delayed to match data_out_o
- data_valid_o  output  1  output beat qualifier

Behaviour:
- Reset: data_out_o=0, data_k_out_o=0, data_valid_o=0, lfsr=LFSR_SEED, ts_cnt=0, com_pending=0, pipeline registers cleared. Reset mid-stream discards in-flight beats; the first output after reset is the first post-reset input.
- Latency: fixed 2 cycles. Stage 1 registers input, K flags and per-byte classification. Stage 2 registers the XOR result. data_valid_o is data_valid_i delayed 2 cycles.
- data_valid_i=0: lfsr, ts_cnt and com_pending hold; the pipeline still shifts (the invalid beat propagates with valid=0).
- LFSR:
  - Polynomial X^16+X^5+X^4+X^3+1, Galois form, bit-serial.
  - Symbol bit k (k=0 first) is XORed with the LFSR output bit, then the LFSR advances one shift.
  - 8 shifts per advanced symbol.
  - Bit-exact with the TX scrambler: the all-zero D stream after COM scrambles to FF 17 C0 14 B2 E7 02 82.
- Per-byte rules, processed sequentially byte 0 to byte N-1 within a beat, with state chained combinationally across bytes:
  - COM (K28.5): output unchanged; LFSR for the next symbol = LFSR_SEED; ts_cnt=TS_BODY_LEN; com_pending=1.
  - SKP (K28.0): output unchanged; LFSR does not advance. If com_pending=1, ts_cnt=0.
  - Any other K symbol (incl. PAD, IDL, FTS, STP, SDP, END, EDB): output unchanged; LFSR advances 8.
  - D symbol: LFSR advances 8. Output = input XOR LFSR byte, except output = input when ts_cnt>0 or disable_scrambling_i=1.
  - Every non-COM symbol clears com_pending. Every non-COM, non-SKP symbol with ts_cnt>0 decrements ts_cnt (saturates at 0).
- COM/SKP split across beats (COM in the last active byte, SKP in byte 0 of the next valid beat) is handled via the registered com_pending. Result is identical to the same-beat case.
- A COM inside the TS window restarts the window (ts_cnt reloaded).
- Bytes >= N: data_out_o byte = 0, K bit = 0, no effect on state.
- pipe_width_i changes only while the lane is idle/reset; behaviour across a mid-stream change is unspecified.
- disable_scrambling_i is sampled with the same beat's data.

Test Plan:
- Reset then width 32: beat {K:COM,D:FF,D:17,D:C0} followed by {D:14,D:B2,D:E7,D:02}, with disable=0 and no TS window (set TS_BODY_LEN=0) -> bytes after COM output 00, COM passes with K=1; data_valid_o asserts exactly 2 cycles after input.
- Same stream at width 8 (one symbol/beat) with valid gaps every other cycle -> identical descrambled sequence; no LFSR advance on invalid cycles.
- Default TS_BODY_LEN: COM + 15 D symbols 0x4A (TS1 body) + D 0xFF -> 15 symbols emerge as 0x4A; the 17th symbol descrambles with the LFSR advanced 15 symbols past seed.
- SKP OS (COM,SKP,SKP,SKP) at width 16 split across beats, then D FF -> no TS bypass, SKPs do not advance the LFSR, FF descrambles to 00.
- disable_scrambling_i=1 with random D/K traffic -> data_out_o equals data_in_i delayed 2 cycles; deassert followed by COM resynchronises.
- Assert rst_i mid-TS window -> outputs 0 next cycle; post-reset COM,FF decodes to 00.

Source files
------------

// File: rtl/gen1_descramble.sv
// Gen1/Gen2 receive-lane descrambler: strips LFSR scrambling from D symbols, passes K symbols.
// Two-stage pipeline; LFSR/TS-window state is chained across the active bytes of a beat.
module gen1_descramble #(
   parameter logic [15:0] LFSR_SEED   = 16'hFFFF,
   parameter int unsigned TS_BODY_LEN = 15
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic [31:0] data_in_i,
   input  logic [3:0]  data_k_in_i,
   input  logic        data_valid_i,
   input  logic [5:0]  pipe_width_i,
   input  logic        disable_scrambling_i,
   output logic [31:0] data_out_o,
   output logic [3:0]  data_k_out_o,
   output logic        data_valid_o
);

   localparam logic [7:0]     SymCom   = 8'hBC;  // K28.5
   localparam logic [7:0]     SymSkp   = 8'h1C;  // K28.0
   localparam logic [15:0]    LfsrTaps = 16'h0039;
   localparam int unsigned    TsW      = (TS_BODY_LEN < 2) ? 1 : $clog2(TS_BODY_LEN + 1);
   localparam logic [TsW-1:0] TsLoad   = TsW'(TS_BODY_LEN);

   // Returns {key byte, LFSR after 8 Galois shifts}; key bit k is the MSB before shift k.
   function automatic logic [23:0] lfsr_step8(input logic [15:0] seed);
      logic [15:0] s;
      logic [7:0]  key;
      s   = seed;
      key = '0;
      for (int b = 0; b < 8; b++) begin
         key[b] = s[15];
         s      = {s[14:0], 1'b0} ^ (s[15] ? LfsrTaps : 16'h0000);
      end
      return {key, s};
   endfunction

   // Scrambler state
   logic [15:0]    lfsr_q, lfsr_d;
   logic [TsW-1:0] ts_cnt_q, ts_cnt_d;
   logic           com_pending_q, com_pending_d;

   // Stage 1 registers
   logic [31:0] s1_data_q;
   logic [3:0]  s1_k_q;
   logic [3:0]  s1_active_q;
   logic [31:0] s1_mask_q;
   logic        s1_valid_q;

   // Combinational per-byte chain
   logic [15:0]    lfsr_c;
   logic [TsW-1:0] ts_c;
   logic           pend_c;
   logic [31:0]    mask_c;
   logic [3:0]     active_c;
   logic [5:0]     num_bytes;
   logic [23:0]    step;
   logic [7:0]     sym;
   logic           is_k;

   assign num_bytes = pipe_width_i >> 3;

   always_comb begin
      lfsr_c   = lfsr_q;
      ts_c     = ts_cnt_q;
      pend_c   = com_pending_q;
      mask_c   = '0;
      active_c = '0;
      step     = '0;
      sym      = '0;
      is_k     = 1'b0;
      for (int i = 0; i < 4; i++) begin
         sym         = data_in_i[8*i +: 8];
         is_k        = data_k_in_i[i];
         active_c[i] = (6'(i) < num_bytes);
         if (active_c[i]) begin
            step = lfsr_step8(lfsr_c);
            if (is_k && sym == SymCom) begin
               lfsr_c = LFSR_SEED;
               ts_c   = TsLoad;
               pend_c = 1'b1;
            end else if (is_k && sym == SymSkp) begin
               // SKP right after COM marks a SKP ordered set, not a training set.
               if (pend_c) begin
                  ts_c = '0;
               end
               pend_c = 1'b0;
            end else begin
               if (!is_k && ts_c == '0 && !disable_scrambling_i) begin
                  mask_c[8*i +: 8] = step[23:16];
               end
               lfsr_c = step[15:0];
               if (ts_c != '0) begin
                  ts_c = ts_c - TsW'(1);
               end
               pend_c = 1'b0;
            end
         end
      end
   end

   always_comb begin
      lfsr_d        = lfsr_q;
      ts_cnt_d      = ts_cnt_q;
      com_pending_d = com_pending_q;
      if (data_valid_i) begin
         lfsr_d        = lfsr_c;
         ts_cnt_d      = ts_c;
         com_pending_d = pend_c;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         lfsr_q        <= LFSR_SEED;
         ts_cnt_q      <= '0;
         com_pending_q <= 1'b0;
      end else begin
         lfsr_q        <= lfsr_d;
         ts_cnt_q      <= ts_cnt_d;
         com_pending_q <= com_pending_d;
      end
   end

   // Stage 1: raw symbols plus per-byte classification and key mask.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         s1_data_q   <= '0;
         s1_k_q      <= '0;
         s1_active_q <= '0;
         s1_mask_q   <= '0;
         s1_valid_q  <= 1'b0;
      end else begin
         s1_data_q   <= data_in_i;
         s1_k_q      <= data_k_in_i;
         s1_active_q <= active_c;
         s1_mask_q   <= mask_c;
         s1_valid_q  <= data_valid_i;
      end
   end

   logic [31:0] s2_data_d;
   logic [3:0]  s2_k_d;

   always_comb begin
      s2_data_d = '0;
      s2_k_d    = '0;
      for (int i = 0; i < 4; i++) begin
         if (s1_active_q[i]) begin
            s2_data_d[8*i +: 8] = s1_data_q[8*i +: 8] ^ s1_mask_q[8*i +: 8];
            s2_k_d[i]           = s1_k_q[i];
         end
      end
   end

   // Stage 2: descrambled output
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         data_out_o   <= '0;
         data_k_out_o <= '0;
         data_valid_o <= 1'b0;
      end else begin
         data_out_o   <= s2_data_d;
         data_k_out_o <= s2_k_d;
         data_valid_o <= s1_valid_q;
      end
   end

endmodule
